ray_setup_gen: RTL and testbench

Per-frame ray setup generator and transmitter. It feeds the DDA block's 120-bit push interface (dda_data_in / push_in).
On a frame start it walks screen columns x = 0..SCREEN_WIDTH-1. For each column it computes cameraX, rayDir, deltaDist, sideDist and the map cell, packs them and pushes one word.
It sits between the player/camera state registers and the DDA FIFO. stall_in carries FIFO backpressure so that no word is ever dropped.

---
 rtl/ray_setup_gen_if.sv | 10 +
 rtl/ray_setup_gen.sv | 190 +++++++++++++++++++
 tb/tb_ray_setup_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_setup_gen_if.sv
// Push-side link from the ray setup generator to the DDA FIFO.
// The master produces ray words and the push strobe. The slave returns backpressure.
interface ray_setup_gen_if;
   logic [119:0] dda_data_out;
   logic         push_out;
   logic         stall_in;

   modport master (output dda_data_out, output push_out, input stall_in);
   modport slave  (input dda_data_out, input push_out, output stall_in);
endinterface

// File: rtl/ray_setup_gen.sv
// Per-frame ray setup generator: walks columns, computes cameraX/rayDir/deltaDist/sideDist
// with one shared restoring divider, and pushes one packed 120-bit word per column.
module ray_setup_gen #(
   parameter int SCREEN_WIDTH = 256,
   parameter int N            = 24
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic        frame_start_in,
   input  logic [15:0] pos_x_in,
   input  logic [15:0] pos_y_in,
   input  logic [15:0] dir_x_in,
   input  logic [15:0] dir_y_in,
   input  logic [15:0] plane_x_in,
   input  logic [15:0] plane_y_in,
   output logic        busy_out,
   output logic        frame_done_out,
   ray_setup_gen_if.master dda
);

   if (SCREEN_WIDTH > 256 || (SCREEN_WIDTH & (SCREEN_WIDTH - 1)) != 0 || N > 256) begin : g_bad_param
      $error("ray_setup_gen: SCREEN_WIDTH must be a power of 2 <= 256 and N <= 256");
   end

   localparam logic [4:0] DIV_LAST = 5'd24;
   localparam logic [7:0] X_LAST   = 8'(SCREEN_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, CAMX, RAYDIR, DDX, DDY, SIDE, PUSH, DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  x_cnt, x_next;
   logic [4:0]  cyc, cyc_next;
   logic        busy_next, push_next, done_next;

   logic [15:0] pos_x_q, pos_y_q, dir_x_q, dir_y_q, plane_x_q, plane_y_q;
   logic [15:0] cam_x, ray_x, ray_y, delta_x, delta_y, side_x, side_y;

   logic [15:0] div_rem, div_den, rem_nxt;
   logic [23:0] div_quo, quo_nxt, div_num_ld;
   logic [15:0] div_den_ld;
   logic [16:0] rem_sh;
   logic        div_ge, div_state, div_load;

   function automatic logic [15:0] ray_sum(input logic [15:0] d, input logic [15:0] p,
                                           input logic [15:0] c);
      logic signed [31:0] prod;
      logic signed [31:0] sum;
      prod = 32'($signed(p)) * 32'($signed(c));
      sum  = 32'($signed(d)) + (prod >>> 8);
      if (sum > 32'sd32767)       return 16'h7FFF;
      else if (sum < -32'sd32768) return 16'h8000;
      else                        return sum[15:0];
   endfunction

   function automatic logic [15:0] delta_sat(input logic [23:0] q);
      return (|q[23:16]) ? 16'hFFFF : q[15:0];
   endfunction

   function automatic logic [15:0] side_dist(input logic neg, input logic [7:0] frac,
                                             input logic [15:0] dd);
      logic [8:0]  f;
      logic [24:0] prod;
      f    = neg ? {1'b0, frac} : 9'd256 - {1'b0, frac};
      prod = 25'(f) * 25'(dd);
      return prod[24] ? 16'hFFFF : prod[23:8];
   endfunction

   // One restoring step: shift in the next dividend bit, subtract when it fits.
   always_comb begin
      rem_sh  = {div_rem, div_quo[23]};
      div_ge  = rem_sh >= {1'b0, div_den};
      quo_nxt = {div_quo[22:0], div_ge};
      rem_nxt = div_ge ? 16'(rem_sh - {1'b0, div_den}) : rem_sh[15:0];
   end

   always_comb begin
      div_state  = (state == CAMX) || (state == DDX) || (state == DDY);
      div_load   = div_state && (cyc == 5'd0);
      div_num_ld = 24'h01_0000;
      div_den_ld = ray_x[15] ? 16'(-ray_x) : ray_x;
      if (state == CAMX) begin
         div_num_ld = 24'({x_cnt, 9'd0});
         div_den_ld = 16'(SCREEN_WIDTH);
      end else if (state == DDY) begin
         div_den_ld = ray_y[15] ? 16'(-ray_y) : ray_y;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      x_next     = x_cnt;
      cyc_next   = 5'd0;
      busy_next  = busy_out;
      push_next  = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: if (frame_start_in) begin
            state_next = CAMX;
            busy_next  = 1'b1;
            x_next     = 8'd0;
         end
         CAMX, DDX, DDY: begin
            if (cyc == DIV_LAST) begin
               state_next = (state == CAMX) ? RAYDIR : (state == DDX) ? DDY : SIDE;
            end else begin
               cyc_next = cyc + 5'd1;
            end
         end
         RAYDIR: state_next = DDX;
         SIDE:   state_next = PUSH;
         PUSH: if (!dda.stall_in) begin
            push_next = 1'b1;
            if (x_cnt == X_LAST) begin
               state_next = DONE;
            end else begin
               x_next     = x_cnt + 8'd1;
               state_next = CAMX;
            end
         end
         DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk_in) begin
      if (!rst_in) begin
         state            <= IDLE;
         x_cnt            <= 8'd0;
         cyc              <= 5'd0;
         busy_out         <= 1'b0;
         frame_done_out   <= 1'b0;
         dda.push_out     <= 1'b0;
         dda.dda_data_out <= '0;
      end else begin
         state          <= state_next;
         x_cnt          <= x_next;
         cyc            <= cyc_next;
         busy_out       <= busy_next;
         frame_done_out <= done_next;
         dda.push_out   <= push_next;
         if (push_next) begin
            dda.dda_data_out <= {x_cnt, ray_x, ray_y, side_x, side_y, delta_x, delta_y,
                                 pos_x_q[15:8], pos_y_q[15:8]};
         end
      end
   end

   // NOTE: datapath registers carry no reset; each is written before the control path reads it.
   always_ff @(posedge pixel_clk_in) begin
      if (state == IDLE && frame_start_in) begin
         pos_x_q   <= pos_x_in;
         pos_y_q   <= pos_y_in;
         dir_x_q   <= dir_x_in;
         dir_y_q   <= dir_y_in;
         plane_x_q <= plane_x_in;
         plane_y_q <= plane_y_in;
      end

      if (div_load) begin
         div_rem <= 16'd0;
         div_quo <= div_num_ld;
         div_den <= div_den_ld;
      end else if (div_state) begin
         div_rem <= rem_nxt;
         div_quo <= quo_nxt;
      end

      case (state)
         CAMX:   if (cyc == DIV_LAST) cam_x <= quo_nxt[15:0] - 16'd256;
         RAYDIR: begin
            ray_x <= ray_sum(dir_x_q, plane_x_q, cam_x);
            ray_y <= ray_sum(dir_y_q, plane_y_q, cam_x);
         end
         // A zero ray direction never reaches the wall on that axis.
         DDX: if (cyc == DIV_LAST) delta_x <= (ray_x == 16'd0) ? 16'hFFFF : delta_sat(quo_nxt);
         DDY: if (cyc == DIV_LAST) delta_y <= (ray_y == 16'd0) ? 16'hFFFF : delta_sat(quo_nxt);
         SIDE: begin
            side_x <= side_dist(ray_x[15], pos_x_q[7:0], delta_x);
            side_y <= side_dist(ray_y[15], pos_y_q[7:0], delta_y);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ray_setup_gen.sv
// Self-checking bench for ray_setup_gen: directed vector, random frames with stall,
// ignored mid-frame inputs, and mid-frame reset, against an arithmetic reference model.
module tb_ray_setup_gen;
   localparam int SW     = 256;
   localparam int PERIOD = 78;

   logic        pixel_clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        frame_start_in = 1'b0;
   logic [15:0] pos_x_in = '0, pos_y_in = '0, dir_x_in = '0, dir_y_in = '0;
   logic [15:0] plane_x_in = '0, plane_y_in = '0;
   logic        busy_out, frame_done_out;

   ray_setup_gen_if dda_if ();

   ray_setup_gen #(.SCREEN_WIDTH(SW), .N(24)) dut (
      .pixel_clk_in  (pixel_clk_in),
      .rst_in        (rst_in),
      .frame_start_in(frame_start_in),
      .pos_x_in      (pos_x_in),
      .pos_y_in      (pos_y_in),
      .dir_x_in      (dir_x_in),
      .dir_y_in      (dir_y_in),
      .plane_x_in    (plane_x_in),
      .plane_y_in    (plane_y_in),
      .busy_out      (busy_out),
      .frame_done_out(frame_done_out),
      .dda           (dda_if.master)
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   int total = 0;
   int bad   = 0;
   logic [119:0] exp_hold = '0;
   logic [119:0] got_word [SW];
   int           got_time [SW];
   int           got_n;

   task automatic tick();
      @(posedge pixel_clk_in);
      #1;
   endtask

   function automatic int clamp_s16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int recip(input int r);
      int q;
      if (r == 0) return 65535;
      q = 65536 / ((r < 0) ? -r : r);
      return (q > 65535) ? 65535 : q;
   endfunction

   function automatic int side_ref(input int r, input int frac, input int dd);
      int s;
      s = (((r < 0) ? frac : 256 - frac) * dd) >> 8;
      return (s > 65535) ? 65535 : s;
   endfunction

   function automatic logic [119:0] model_word(input int x, input logic [15:0] px, py, dx, dy,
                                                plx, ply);
      int cam, rx, ry, ddx, ddy, sx, sy;
      cam = (x * 512) / SW - 256;
      rx  = clamp_s16($signed(dx) + (($signed(plx) * cam) >>> 8));
      ry  = clamp_s16($signed(dy) + (($signed(ply) * cam) >>> 8));
      ddx = recip(rx);
      ddy = recip(ry);
      sx  = side_ref(rx, int'(px[7:0]), ddx);
      sy  = side_ref(ry, int'(py[7:0]), ddy);
      return {8'(x), 16'(rx), 16'(ry), 16'(sx), 16'(sy), 16'(ddx), 16'(ddy), px[15:8], py[15:8]};
   endfunction

   function automatic int exp_time(input int c, input int stall_col, input int stall_len);
      return PERIOD * (c + 1) + ((stall_col >= 0 && c >= stall_col) ? stall_len : 0);
   endfunction

   task automatic random_inputs();
      pos_x_in   = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 255))};
      pos_y_in   = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 255))};
      dir_x_in   = 16'($urandom);
      dir_y_in   = 16'($urandom);
      plane_x_in = 16'($urandom);
      plane_y_in = 16'($urandom);
   endtask

   // Runs one whole frame from IDLE and checks every push against the model and the schedule.
   task automatic run_frame(input logic [15:0] px, py, dx, dy, plx, ply,
                            input int stall_col, input int stall_len, input bit perturb);
      int t_last, cyc, done_cnt, done_cyc, extra, t0;
      logic [119:0] exp_w;
      t_last = exp_time(SW - 1, stall_col, stall_len);
      t0     = PERIOD * (stall_col + 1);
      pos_x_in = px; pos_y_in = py; dir_x_in = dx; dir_y_in = dy;
      plane_x_in = plx; plane_y_in = ply;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      cyc = 0; got_n = 0; done_cnt = 0; done_cyc = -1; extra = 0;
      total++;
      if (busy_out !== 1'b1) begin
         bad++; $display("FAIL busy_on_accept: got %b want 1", busy_out);
      end
      while (cyc < t_last + 2) begin
         dda_if.stall_in = (stall_col >= 0 && cyc >= t0 - 1 && cyc < t0 - 1 + stall_len);
         frame_start_in  = (cyc == t_last) || (perturb && cyc % 500 == 250 && cyc < t_last - 5);
         if (perturb && cyc % 500 == 250) random_inputs();
         if (got_n < SW && cyc == exp_time(got_n, stall_col, stall_len) - 1) begin
            total++;
            if (dda_if.dda_data_out !== exp_hold) begin
               bad++; $display("FAIL data_hold col %0d: got %h want %h", got_n,
                               dda_if.dda_data_out, exp_hold);
            end
         end
         tick();
         cyc++;
         if (stall_col >= 0 && cyc >= t0 && cyc < t0 + stall_len) begin
            total++;
            if (dda_if.push_out !== 1'b0 || dda_if.dda_data_out !== exp_hold) begin
               bad++; $display("FAIL stall_hold cyc %0d: push %b data %h want push 0 data %h",
                               cyc, dda_if.push_out, dda_if.dda_data_out, exp_hold);
            end
         end
         if (dda_if.push_out === 1'b1) begin
            if (got_n < SW) begin
               exp_w = model_word(got_n, px, py, dx, dy, plx, ply);
               total++;
               if (cyc != exp_time(got_n, stall_col, stall_len)) begin
                  bad++; $display("FAIL push_time col %0d: got cycle %0d want %0d", got_n, cyc,
                                  exp_time(got_n, stall_col, stall_len));
               end
               total++;
               if (dda_if.dda_data_out !== exp_w) begin
                  bad++; $display("FAIL push_word col %0d: got %h want %h", got_n,
                                  dda_if.dda_data_out, exp_w);
               end
               got_word[got_n] = dda_if.dda_data_out;
               got_time[got_n] = cyc;
               exp_hold = exp_w;
            end else begin
               extra++;
            end
            got_n++;
         end
         if (frame_done_out === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc == t_last || cyc == t_last + 1 || cyc == t_last + 2) begin
            total++;
            if (busy_out !== (cyc == t_last)) begin
               bad++; $display("FAIL busy_end cyc %0d: got %b want %b", cyc, busy_out,
                               cyc == t_last);
            end
         end
      end
      frame_start_in  = 1'b0;
      dda_if.stall_in = 1'b0;
      total++;
      if (got_n != SW || extra != 0) begin
         bad++; $display("FAIL push_count: got %0d want %0d", got_n, SW);
      end
      total++;
      if (done_cnt != 1 || done_cyc != t_last + 1) begin
         bad++; $display("FAIL frame_done: got %0d pulses last at %0d want 1 at %0d",
                         done_cnt, done_cyc, t_last + 1);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) tick();
      total++;
      if (dda_if.push_out !== 1'b0 || busy_out !== 1'b0 || frame_done_out !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl: push %b busy %b done %b want 0 0 0",
                         dda_if.push_out, busy_out, frame_done_out);
      end
      total++;
      if (dda_if.dda_data_out !== 120'd0) begin
         bad++; $display("FAIL reset_data: got %h want 0", dda_if.dda_data_out);
      end
      rst_in = 1'b1;
      repeat (2) tick();
      total++;
      if (busy_out !== 1'b0 || dda_if.push_out !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: busy %b push %b want 0 0", busy_out,
                         dda_if.push_out);
      end
      exp_hold = '0;
   endtask

   task automatic test_first_frame();
      run_frame(16'h0C80, 16'h0C80, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9, -1, 0, 1'b0);
      total++;
      if (got_word[0] !== 120'h00_FF00_FF57_0080_00C1_0100_0183_0C_0C) begin
         bad++; $display("FAIL col0_word: got %h want %h", got_word[0],
                         120'h00_FF00_FF57_0080_00C1_0100_0183_0C_0C);
      end
      total++;
      if (got_time[0] != 78) begin
         bad++; $display("FAIL col0_latency: got %0d want 78", got_time[0]);
      end
      total++;
      if (got_word[128] !== 120'h80_FF00_0000_0080_7FFF_0100_FFFF_0C_0C) begin
         bad++; $display("FAIL col128_word: got %h want %h", got_word[128],
                         120'h80_FF00_0000_0080_7FFF_0100_FFFF_0C_0C);
      end
   endtask

   task automatic test_reset_midframe();
      int cyc, n;
      pos_x_in = 16'h0C80; pos_y_in = 16'h0C80; dir_x_in = 16'hFF00; dir_y_in = 16'h0000;
      plane_x_in = 16'h0000; plane_y_in = 16'h00A9;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      cyc = 0; n = 0;
      while (cyc < PERIOD * 3 + 61) begin
         if (cyc == PERIOD * 3 + 60) rst_in = 1'b0;
         tick();
         cyc++;
         if (dda_if.push_out === 1'b1) n++;
      end
      total++;
      if (n != 3) begin
         bad++; $display("FAIL pushes_before_reset: got %0d want 3", n);
      end
      total++;
      if (dda_if.push_out !== 1'b0 || busy_out !== 1'b0 || frame_done_out !== 1'b0 ||
          dda_if.dda_data_out !== 120'd0) begin
         bad++; $display("FAIL midframe_reset: push %b busy %b done %b data %h want all 0",
                         dda_if.push_out, busy_out, frame_done_out, dda_if.dda_data_out);
      end
      rst_in = 1'b1;
      exp_hold = '0;
      n = 0;
      repeat (200) begin
         tick();
         if (dda_if.push_out === 1'b1 || busy_out === 1'b1) n++;
      end
      total++;
      if (n != 0) begin
         bad++; $display("FAIL quiet_after_reset: got %0d active cycles want 0", n);
      end
   endtask

   task automatic test_backpressure_perturb();
      logic [15:0] px, py, dx, dy, plx, ply;
      px  = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 255))};
      py  = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 255))};
      dx  = 16'($urandom);
      dy  = 16'($urandom);
      plx = 16'($urandom);
      ply = 16'($urandom);
      run_frame(px, py, dx, dy, plx, ply, 5, 10, 1'b1);
   endtask

   initial begin
      dda_if.stall_in = 1'b0;
      test_reset();
      test_first_frame();
      test_reset_midframe();
      test_backpressure_perturb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
